// File: rtl/timed_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | timed_mem : clocked memory model with independent fixed-latency read  |
// |             and write channels, byte enables and range flags          |
// | Revision  : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module timed_mem #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 256,
  parameter int          R_LAT    = 15,
  parameter int          W_LAT    = 15,
  parameter logic [31:0] FILL_VAL = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                re,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   d_out,
  output logic                r_finished,
  output logic                r_err,
  input  logic                we,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   d_in,
  input  logic [DATA_W/8-1:0] w_be,
  output logic                w_finished,
  output logic                w_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RCNT_W = (R_LAT > 1) ? $clog2(R_LAT) : 1;
  localparam int WCNT_W = (W_LAT > 1) ? $clog2(W_LAT) : 1;
  localparam int REP    = (DATA_W + 31) / 32;

  localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'({REP{FILL_VAL}});
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [RCNT_W-1:0] R_LOAD    = RCNT_W'(R_LAT - 1);
  localparam logic [WCNT_W-1:0] W_LOAD    = WCNT_W'(W_LAT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read channel state
  state_e            rd_state_q, rd_state_d;
  logic [RCNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              r_finished_q, r_finished_d;
  logic              r_err_q, r_err_d;

  // Write channel state
  state_e            wr_state_q, wr_state_d;
  logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [BE_W-1:0]   wr_be_q, wr_be_d;
  logic              w_finished_q, w_finished_d;
  logic              w_err_q, w_err_d;

  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_commit;
  logic [DATA_W-1:0] wr_word;

  assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_LIM);
  assign rd_idx      = rd_addr_q[IDX_W-1:0];
  assign wr_idx      = wr_addr_q[IDX_W-1:0];

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_addr_d    = rd_addr_q;
    d_out_d      = d_out_q;
    r_finished_d = r_finished_q;
    r_err_d      = r_err_q;
    case (rd_state_q)
      ST_IDLE: begin
        if (re) begin
          rd_addr_d    = r_addr;
          rd_cnt_d     = R_LOAD;
          r_finished_d = 1'b0;
          rd_state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rd_cnt_q == '0) begin
          // mem_q is sampled before this edge's write commit: read-before-write
          if (rd_in_range) begin
            d_out_d = mem_q[rd_idx];
            r_err_d = 1'b0;
          end else begin
            d_out_d = FILL_WORD;
            r_err_d = 1'b1;
          end
          r_finished_d = 1'b1;
          rd_state_d   = ST_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q - RCNT_W'(1);
        end
      end
      default: rd_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_cnt_d     = wr_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    w_finished_d = w_finished_q;
    w_err_d      = w_err_q;
    wr_commit    = 1'b0;
    case (wr_state_q)
      ST_IDLE: begin
        if (we) begin
          wr_addr_d    = w_addr;
          wr_data_d    = d_in;
          wr_be_d      = w_be;
          wr_cnt_d     = W_LOAD;
          w_finished_d = 1'b0;
          wr_state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (wr_cnt_q == '0) begin
          wr_commit    = wr_in_range;
          w_err_d      = !wr_in_range;
          w_finished_d = 1'b1;
          wr_state_d   = ST_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q - WCNT_W'(1);
        end
      end
      default: wr_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_word = mem_q[wr_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be_q[b]) begin
        wr_word[8*b +: 8] = wr_data_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= FILL_WORD;
      end
    end else if (wr_commit) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q   <= ST_IDLE;
      rd_cnt_q     <= '0;
      rd_addr_q    <= '0;
      d_out_q      <= '0;
      r_finished_q <= 1'b1;
      r_err_q      <= 1'b0;
      wr_state_q   <= ST_IDLE;
      wr_cnt_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      w_finished_q <= 1'b1;
      w_err_q      <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_addr_q    <= rd_addr_d;
      d_out_q      <= d_out_d;
      r_finished_q <= r_finished_d;
      r_err_q      <= r_err_d;
      wr_state_q   <= wr_state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      w_finished_q <= w_finished_d;
      w_err_q      <= w_err_d;
    end
  end

  assign d_out      = d_out_q;
  assign r_finished = r_finished_q;
  assign r_err      = r_err_q;
  assign w_finished = w_finished_q;
  assign w_err      = w_err_q;

endmodule
`default_nettype wire

// File: tb/tb_timed_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_timed_mem : scoreboard bench for timed_mem, directed + random      |
// | Revision     : 1.0  initial release                                   |
// +------------------------------------------------------------------------+
module tb_timed_mem;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 128;
  localparam int          R_LAT  = 3;
  localparam int          W_LAT  = 3;
  localparam logic [31:0] FILL   = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset;
  logic              re, we;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] d_in, d_out;
  logic [3:0]        w_be;
  logic              r_finished, r_err, w_finished, w_err;

  timed_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .R_LAT(R_LAT), .W_LAT(W_LAT), .FILL_VAL(FILL)
  ) dut (
    .clk(clk), .reset(reset),
    .re(re), .r_addr(r_addr), .d_out(d_out), .r_finished(r_finished), .r_err(r_err),
    .we(we), .w_addr(w_addr), .d_in(d_in), .w_be(w_be),
    .w_finished(w_finished), .w_err(w_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: each accepted request completes LAT edges later;
  // the channel accepts again only once nothing is pending.
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  logic [31:0] mdl_mem [DEPTH];
  rd_exp_t     rd_q [$];
  bit          wr_q [$];
  bit          r_pend = 0, w_pend = 0;
  int          r_due, w_due;
  logic [7:0]  r_a, w_a;
  logic [31:0] w_d;
  logic [3:0]  w_b;
  int          ecnt = 0;
  bit          rst_seen = 0;

  always @(posedge clk) begin
    bit r_idle, w_idle;
    ecnt++;
    rst_seen = reset;
    if (reset) begin
      r_pend = 0;
      w_pend = 0;
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = FILL;
    end else begin
      r_idle = !r_pend;
      w_idle = !w_pend;
      if (r_pend && ecnt == r_due) begin
        if (int'(r_a) < DEPTH) rd_q.push_back('{data: mdl_mem[r_a], err: 1'b0});
        else                   rd_q.push_back('{data: FILL, err: 1'b1});
        r_pend = 0;
      end
      if (w_pend && ecnt == w_due) begin
        if (int'(w_a) < DEPTH) begin
          for (int b = 0; b < 4; b++)
            if (w_b[b]) mdl_mem[w_a][8*b +: 8] = w_d[8*b +: 8];
          wr_q.push_back(1'b0);
        end else begin
          wr_q.push_back(1'b1);
        end
        w_pend = 0;
      end
      if (re && r_idle) begin
        r_pend = 1; r_due = ecnt + R_LAT; r_a = r_addr;
      end
      if (we && w_idle) begin
        w_pend = 1; w_due = ecnt + W_LAT; w_a = w_addr; w_d = d_in; w_b = w_be;
      end
    end
  end

  // Monitor: pops an expectation on each finished rise, then checks that
  // outputs hold the last completed result every cycle.
  bit          armed = 0;
  logic        prev_rf = 1'b1, prev_wf = 1'b1;
  logic [31:0] last_d;
  logic        last_re, last_we;

  always @(negedge clk) begin
    if (rst_seen) begin
      armed   = 1;
      last_d  = '0;
      last_re = 1'b0;
      last_we = 1'b0;
    end else if (armed) begin
      if (!prev_rf && r_finished) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_underflow: got completion expected none at t=%0t", $time);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          last_d  = e.data;
          last_re = e.err;
        end
      end
      if (!prev_wf && w_finished) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_underflow: got completion expected none at t=%0t", $time);
        end else begin
          last_we = wr_q.pop_front();
        end
      end
    end
    if (armed) begin
      chk("rd_data",    d_out,             last_d);
      chk("rd_err",     32'(r_err),        32'(last_re));
      chk("r_finished", 32'(r_finished),   32'(!r_pend));
      chk("w_finished", 32'(w_finished),   32'(!w_pend));
      chk("wr_err",     32'(w_err),        32'(last_we));
    end
    prev_rf = r_finished;
    prev_wf = w_finished;
  end

  task automatic wait_idle();
    int k = 0;
    while ((!r_finished || !w_finished) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy expected idle within 100 cycles");
    end
  endtask

  task automatic rd(input logic [7:0] a);
    @(negedge clk); #1;
    re = 1'b1; r_addr = a;
    @(negedge clk); #1;
    re = 1'b0;
    wait_idle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk); #1;
    we = 1'b1; w_addr = a; d_in = d; w_be = be;
    @(negedge clk); #1;
    we = 1'b0;
    wait_idle();
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    reset = 1'b1; re = 1'b0; we = 1'b0;
    r_addr = '0; w_addr = '0; d_in = '0; w_be = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    chk("rst_dout", d_out, 32'h0);
    chk("rst_rfin", 32'(r_finished), 32'h1);
    chk("rst_wfin", 32'(w_finished), 32'h1);

    rd(8'h10);
    chk("fill_read", d_out, 32'hDEADBEEF);
    chk("fill_rerr", 32'(r_err), 32'h0);

    wr(8'h04, 32'h12345678, 4'hF);
    rd(8'h04);
    chk("full_write", d_out, 32'h12345678);
    wr(8'h04, 32'hAABBCCDD, 4'b0101);
    rd(8'h04);
    chk("byte_write", d_out, 32'h12BB56DD);

    @(negedge clk); #1;
    re = 1'b1; r_addr = 8'h20;
    we = 1'b1; w_addr = 8'h20; d_in = 32'h55667788; w_be = 4'hF;
    @(negedge clk); #1;
    re = 1'b0; we = 1'b0;
    wait_idle();
    chk("rbw_old", d_out, 32'hDEADBEEF);
    rd(8'h20);
    chk("rbw_new", d_out, 32'h55667788);

    rd(8'hC0);
    chk("oor_rdata", d_out, 32'hDEADBEEF);
    chk("oor_rerr",  32'(r_err), 32'h1);
    wr(8'hC0, 32'h11223344, 4'hF);
    chk("oor_werr",  32'(w_err), 32'h1);
    rd(8'h40);
    chk("alias_untouched", d_out, 32'hDEADBEEF);
    chk("inrange_rerr", 32'(r_err), 32'h0);

    for (int i = 0; i < 16; i++) wr(8'(i), 32'hA5000000 | 32'(i), 4'hF);
    @(negedge clk); #1;
    re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r_addr = 8'($urandom_range(0, 15));
      @(negedge clk); #1;
    end
    re = 1'b0;
    wait_idle();

    @(negedge clk); #1;
    we = 1'b1; w_addr = 8'h01; d_in = 32'h0BADF00D; w_be = 4'hF;
    @(negedge clk); #1;
    we = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("abort_wfin", 32'(w_finished), 32'h1);
    repeat (5) @(negedge clk);
    rd(8'h01);
    chk("abort_nocommit", d_out, 32'hDEADBEEF);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      reset  = ($urandom_range(0, 299) == 0);
      re     = 1'($urandom_range(0, 1));
      r_addr = pick_addr();
      we     = 1'($urandom_range(0, 1));
      w_addr = pick_addr();
      d_in   = $urandom;
      w_be   = 4'($urandom_range(0, 15));
    end
    @(negedge clk); #1;
    reset = 1'b0; re = 1'b0; we = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("rd_q_empty", 32'(rd_q.size()), 32'h0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
